// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: command word fields, opcodes,
// FSM encoding, response constants and a saturating counter helper.
package spi_cmd_pkg;

  localparam int CMD_W       = 32;
  localparam int OP_MSB      = 31;
  localparam int OP_LSB      = 30;
  localparam int ADDR_MSB    = 29;
  localparam int ADDR_LSB    = 24;
  localparam int PAYLOAD_MSB = 23;
  localparam int PAYLOAD_LSB = 0;
  localparam int PAYLOAD_W   = PAYLOAD_MSB - PAYLOAD_LSB + 1;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CTRL  = 2'b11;

  localparam logic [5:0]  FRAME_BITS    = 6'd32;
  localparam logic [7:0]  STATUS_TAG    = 8'hA5;
  localparam logic [23:0] BAD_ADDR_DATA = 24'hBADBAD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DECODE,
    ST_EXEC,
    ST_RESP
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Three-flop synchroniser with rise/fall detection on stages [2:1],
// matching the edge timing of the SPI shift stage.
module spi_edge_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], din};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {3{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_cmd_decoder.sv
// Frames SPI transfers, decodes 32-bit commands into an actuator register bank
// and loads a response word. Optional CAPTURE timeout: define SPI_CMD_TIMEOUT_EN.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int DATA_W      = 24,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       sclk,
  input  logic                       ss_n,
  input  logic [31:0]                spi_data_out,
  output logic [31:0]                spi_data_in,
  output logic                       spi_data_valid_n,
  output logic                       spi_enable_sn,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       reg_we,
  output logic [5:0]                 reg_waddr,
  output logic [7:0]                 err_cnt,
  output logic [7:0]                 frame_cnt
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;

  spi_edge_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (sclk),
    .level   (sclk_level),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  // ss_n idles high, so its synchroniser resets high to avoid a false fall.
  spi_edge_sync #(.RESET_VAL(1'b1)) u_ss_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (ss_n),
    .level   (ss_level),
    .rise    (ss_rise),
    .fall    (ss_fall)
  );

  logic unused_sclk;
  assign unused_sclk = sclk_level ^ sclk_fall;

  state_t              state_q, state_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [31:0]         cmd_q, cmd_d;
  logic                addr_ok_q, addr_ok_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [31:0]         resp_q, resp_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic [5:0]          reg_waddr_q, reg_waddr_d;
  logic                enable_sn_q, enable_sn_d;
  logic                fall_pend_q, fall_pend_d;

  logic [1:0]            cmd_op;
  logic [5:0]            cmd_addr;
  logic [PAYLOAD_W-1:0]  cmd_payload;

  assign cmd_op      = cmd_q[OP_MSB:OP_LSB];
  assign cmd_addr    = cmd_q[ADDR_MSB:ADDR_LSB];
  assign cmd_payload = cmd_q[PAYLOAD_MSB:PAYLOAD_LSB];

`ifdef SPI_CMD_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = TIMEOUT_CYC[15:0];
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
`else
  localparam logic [15:0] tmo_unused = TIMEOUT_CYC[15:0];
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    addr_ok_d   = addr_ok_q;
    rd_data_d   = rd_data_q;
    regs_d      = regs_q;
    resp_d      = resp_q;
    err_cnt_d   = err_cnt_q;
    frame_cnt_d = frame_cnt_q;
    reg_waddr_d = reg_waddr_q;
    enable_sn_d = 1'b0;
    fall_pend_d = fall_pend_q;
`ifdef SPI_CMD_TIMEOUT_EN
    tmo_cnt_d   = (state_q == ST_CAPTURE) ? tmo_cnt_q + 16'd1 : 16'd0;
`endif

    if (ss_fall) begin
      bit_cnt_d = '0;
    end else if (sclk_rise && !ss_level && bit_cnt_q != 6'd63) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
    end

    // A new frame starting while a command is still in flight is remembered.
    if (ss_fall && (state_q == ST_DECODE || state_q == ST_EXEC || state_q == ST_RESP)) begin
      fall_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (ss_rise) begin
          if (bit_cnt_q == FRAME_BITS) begin
            state_d = ST_DECODE;
            cmd_d   = spi_data_out;
          end else begin
            state_d   = ST_IDLE;
            err_cnt_d = sat_inc8(err_cnt_q);
          end
        end
`ifdef SPI_CMD_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LIMIT) begin
          state_d   = ST_IDLE;
          err_cnt_d = sat_inc8(err_cnt_q);
        end
`endif
      end
      ST_DECODE: begin
        addr_ok_d = (int'(cmd_addr) < NUM_REGS);
        rd_data_d = BAD_ADDR_DATA;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (int'(cmd_addr) == i) begin
            rd_data_d = regs_q[i];
          end
        end
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (cmd_op)
          OP_WRITE: begin
            if (addr_ok_q) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(cmd_addr) == i) begin
                  regs_d[i] = cmd_payload;
                end
              end
              reg_waddr_d = cmd_addr;
            end else begin
              err_cnt_d = sat_inc8(err_cnt_q);
            end
          end
          OP_READ: begin
            if (!addr_ok_q) begin
              err_cnt_d = sat_inc8(err_cnt_q);
            end
          end
          OP_CTRL: begin
            if (cmd_payload[0]) begin
              err_cnt_d = '0;
            end
            if (cmd_payload[1]) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
              end
            end
          end
          default: begin
          end
        endcase
        frame_cnt_d  = frame_cnt_q + 8'd1;
        resp_d[31:24] = cmd_q[31:24];
        if (cmd_op == OP_READ) begin
          resp_d[23:0] = rd_data_q;
        end else begin
          resp_d[23:0] = {STATUS_TAG, err_cnt_d, frame_cnt_d};
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (!ss_level) begin
          err_cnt_d = sat_inc8(err_cnt_q);
        end
        state_d = (fall_pend_q || ss_fall) ? ST_CAPTURE : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_CAPTURE) begin
      fall_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      addr_ok_q   <= 1'b0;
      rd_data_q   <= '0;
      regs_q      <= '{default: '0};
      resp_q      <= '0;
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
      reg_waddr_q <= '0;
      enable_sn_q <= 1'b1;
      fall_pend_q <= 1'b0;
`ifdef SPI_CMD_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      addr_ok_q   <= addr_ok_d;
      rd_data_q   <= rd_data_d;
      regs_q      <= regs_d;
      resp_q      <= resp_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      reg_waddr_q <= reg_waddr_d;
      enable_sn_q <= enable_sn_d;
      fall_pend_q <= fall_pend_d;
`ifdef SPI_CMD_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  // The load is withheld if the master has already begun the next frame.
  assign spi_data_valid_n = ~((state_q == ST_RESP) && ss_level);
  assign spi_data_in      = resp_q;
  assign spi_enable_sn    = enable_sn_q;
  assign reg_we           = (state_q == ST_EXEC) && (cmd_op == OP_WRITE) && addr_ok_q;
  assign reg_waddr        = reg_waddr_q;
  assign err_cnt          = err_cnt_q;
  assign frame_cnt        = frame_cnt_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: directed SPI frames push expected
// responses/writes; independent monitors check load strobes and reg_we pulses.
module tb_spi_cmd_decoder;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 24;

  logic                       clock = 1'b0;
  logic                       reset_n = 1'b0;
  logic                       sclk = 1'b0;
  logic                       ss_n = 1'b1;
  logic [31:0]                spi_data_out = '0;
  logic [31:0]                spi_data_in;
  logic                       spi_data_valid_n;
  logic                       spi_enable_sn;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic                       reg_we;
  logic [5:0]                 reg_waddr;
  logic [7:0]                 err_cnt;
  logic [7:0]                 frame_cnt;

  spi_cmd_decoder #(
    .NUM_REGS    (NUM_REGS),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (100)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .sclk             (sclk),
    .ss_n             (ss_n),
    .spi_data_out     (spi_data_out),
    .spi_data_in      (spi_data_in),
    .spi_data_valid_n (spi_data_valid_n),
    .spi_enable_sn    (spi_enable_sn),
    .regs_flat        (regs_flat),
    .reg_we           (reg_we),
    .reg_waddr        (reg_waddr),
    .err_cnt          (err_cnt),
    .frame_cnt        (frame_cnt)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [31:0]       resp_exp_q [$];
  logic [5:0]        we_exp_q [$];
  logic [DATA_W-1:0] exp_regs [NUM_REGS];

  logic [31:0] mon_resp_exp;
  logic [5:0]  mon_we_addr;
  bit          mon_we_pending = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkRegs(input string name);
    for (int i = 0; i < NUM_REGS; i++) begin
      checkOutput($sformatf("%s_reg%0d", name, i), 64'(regs_flat[i*DATA_W +: DATA_W]), 64'(exp_regs[i]));
    end
  endtask

  // Response monitor: every low cycle of the load strobe must match one queued word.
  always @(negedge clock) begin
    if (reset_n && !spi_data_valid_n) begin
      total++;
      if (resp_exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_load: got %08h expected no load", spi_data_in);
      end else begin
        mon_resp_exp = resp_exp_q.pop_front();
        if (spi_data_in !== mon_resp_exp) begin
          bad++;
          $display("[TB] FAIL resp: got %08h expected %08h", spi_data_in, mon_resp_exp);
        end
      end
    end
  end

  // Write monitor: each reg_we cycle consumes one expected address; reg_waddr is checked a cycle later.
  always @(negedge clock) begin
    if (mon_we_pending) begin
      mon_we_pending = 1'b0;
      total++;
      if (reg_waddr !== mon_we_addr) begin
        bad++;
        $display("[TB] FAIL reg_waddr: got %0d expected %0d", reg_waddr, mon_we_addr);
      end
    end
    if (reset_n && reg_we) begin
      total++;
      if (we_exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_we: got pulse expected none");
      end else begin
        mon_we_addr    = we_exp_q.pop_front();
        mon_we_pending = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] word, input int nbits,
                               input bit has_resp, input logic [31:0] resp,
                               input int we_addr);
    if (has_resp) resp_exp_q.push_back(resp);
    if (we_addr >= 0) we_exp_q.push_back(6'(we_addr));
    @(negedge clock);
    spi_data_out = word;
    ss_n = 1'b0;
    repeat (4) @(negedge clock);
    for (int b = 0; b < nbits; b++) begin
      sclk = 1'b1;
      repeat (3) @(negedge clock);
      sclk = 1'b0;
      repeat (3) @(negedge clock);
    end
    repeat (3) @(negedge clock);
    ss_n = 1'b1;
    repeat (12) @(negedge clock);
  endtask

  task automatic resetDut();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("enable_after_reset", 64'(spi_enable_sn), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst_valid_n", 64'(spi_data_valid_n), 64'd1);
    checkOutput("rst_enable_sn", 64'(spi_enable_sn), 64'd1);
    checkOutput("rst_data_in", 64'(spi_data_in), 64'd0);
    checkOutput("rst_reg_we", 64'(reg_we), 64'd0);
    checkOutput("rst_reg_waddr", 64'(reg_waddr), 64'd0);
    checkOutput("rst_err", 64'(err_cnt), 64'd0);
    checkOutput("rst_frame", 64'(frame_cnt), 64'd0);
    checkRegs("rst");
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checkOutput("enable_first_clk", 64'(spi_enable_sn), 64'd0);

    // Write then read back register 3.
    applyStimulus(32'h4312_3456, 32, 1'b1, 32'h43A5_0001, 3);
    exp_regs[3] = 24'h123456;
    checkRegs("write3");
    checkOutput("write3_waddr", 64'(reg_waddr), 64'd3);
    checkOutput("write3_frame", 64'(frame_cnt), 64'd1);
    checkOutput("write3_err", 64'(err_cnt), 64'd0);
    applyStimulus(32'h8300_0000, 32, 1'b1, 32'h8312_3456, -1);
    checkOutput("read3_frame", 64'(frame_cnt), 64'd2);

    // Short frame is rejected without a load; the following NOP reports it.
    resetDut();
    applyStimulus(32'h0000_0000, 31, 1'b0, 32'h0, -1);
    checkOutput("short_err", 64'(err_cnt), 64'd1);
    checkOutput("short_frame", 64'(frame_cnt), 64'd0);
    checkRegs("short");
    applyStimulus(32'h0000_0000, 32, 1'b1, 32'h00A5_0101, -1);

    // Out-of-range accesses, then a CTRL that clears errors and registers.
    applyStimulus(32'h8900_0000, 32, 1'b1, 32'h89BA_DBAD, -1);
    checkOutput("bad_read_err", 64'(err_cnt), 64'd2);
    applyStimulus(32'h4900_00FF, 32, 1'b1, 32'h49A5_0303, -1);
    checkOutput("bad_write_err", 64'(err_cnt), 64'd3);
    checkRegs("bad_write");
    applyStimulus(32'h4700_ABCD, 32, 1'b1, 32'h47A5_0304, 7);
    exp_regs[7] = 24'h00ABCD;
    checkRegs("write7");
    applyStimulus(32'hC000_0003, 32, 1'b1, 32'hC0A5_0005, -1);
    exp_regs[7] = '0;
    checkOutput("ctrl_err", 64'(err_cnt), 64'd0);
    checkOutput("ctrl_frame", 64'(frame_cnt), 64'd5);
    checkRegs("ctrl");

    // ss_n held low with no clocks: either a timeout or a zero-bit frame error.
    @(negedge clock);
    ss_n = 1'b0;
    repeat (150) @(negedge clock);
`ifdef SPI_CMD_TIMEOUT_EN
    checkOutput("timeout_err", 64'(err_cnt), 64'd1);
`endif
    ss_n = 1'b1;
    repeat (12) @(negedge clock);
    checkOutput("stuck_ss_err", 64'(err_cnt), 64'd1);
    checkOutput("stuck_ss_frame", 64'(frame_cnt), 64'd5);
    applyStimulus(32'h0000_0000, 32, 1'b1, 32'h00A5_0106, -1);

    // Reset asserted in the middle of a frame clears everything at once.
    applyStimulus(32'h4200_0077, 32, 1'b1, 32'h42A5_0107, 2);
    exp_regs[2] = 24'h000077;
    checkRegs("write2");
    @(negedge clock);
    spi_data_out = 32'h4500_0011;
    ss_n = 1'b0;
    repeat (4) @(negedge clock);
    for (int b = 0; b < 5; b++) begin
      sclk = 1'b1;
      repeat (3) @(negedge clock);
      sclk = 1'b0;
      repeat (3) @(negedge clock);
    end
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    checkRegs("midrst");
    checkOutput("midrst_err", 64'(err_cnt), 64'd0);
    checkOutput("midrst_frame", 64'(frame_cnt), 64'd0);
    checkOutput("midrst_valid_n", 64'(spi_data_valid_n), 64'd1);
    checkOutput("midrst_enable_sn", 64'(spi_enable_sn), 64'd1);
    checkOutput("midrst_data_in", 64'(spi_data_in), 64'd0);
    checkOutput("midrst_waddr", 64'(reg_waddr), 64'd0);
    ss_n = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checkOutput("midrst_enable_after", 64'(spi_enable_sn), 64'd0);
    applyStimulus(32'h4100_0001, 32, 1'b1, 32'h41A5_0001, 1);
    exp_regs[1] = 24'h000001;
    checkRegs("post_rst");

    repeat (4) @(negedge clock);
    checkOutput("resp_queue_drained", 64'(resp_exp_q.size()), 64'd0);
    checkOutput("we_queue_drained", 64'(we_exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
